// File: rtl/mem_if_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_if_pkg : shared widths and FSM state encoding for the refill memory port
// Revision   : 1.0
// ---------------------------------------------------------------------------
package mem_if_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_TAG_BITS  = 5;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/ext_mem_model_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ext_mem_model_if : request, write-data and response channels of the memory
// Revision         : 1.0
// ---------------------------------------------------------------------------
interface ext_mem_model_if;
  import mem_if_pkg::*;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_rw;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic [MEM_TAG_BITS-1:0]  mem_req_tag;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
  logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
  logic                     mem_resp_valid;
  logic [MEM_TAG_BITS-1:0]  mem_resp_tag;
  logic [MEM_DATA_BITS-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready,
    input  mem_resp_valid, mem_resp_tag, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready,
    output mem_resp_valid, mem_resp_tag, mem_resp_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_resp_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_resp_pipe : fixed-latency shift register of {valid, tag, data}
// Revision      : 1.0
// ---------------------------------------------------------------------------
module mem_resp_pipe #(
  parameter int LATENCY   = 4,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 in_valid,
  input  wire logic [TAG_BITS-1:0]  in_tag,
  input  wire logic [DATA_BITS-1:0] in_data,
  output logic                      out_valid,
  output logic [TAG_BITS-1:0]       out_tag,
  output logic [DATA_BITS-1:0]      out_data
);

  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q  [LATENCY];
  logic [TAG_BITS-1:0]  tag_d  [LATENCY];
  logic [DATA_BITS-1:0] data_q [LATENCY];
  logic [DATA_BITS-1:0] data_d [LATENCY];

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid;
    tag_d[0]   = in_tag;
    data_d[0]  = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Only the valid bits need clearing; payload may legitimately be stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/ext_mem_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ext_mem_model : line-granular main memory with fixed read latency
// Revision      : 1.0
// ---------------------------------------------------------------------------
module ext_mem_model
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LOG2   = 14,
  parameter int READ_LATENCY = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  ext_mem_model_if.slave mem
);

  localparam logic [0:0] S_IDLE      = IDLE;
  localparam logic [0:0] S_WAIT_DATA = WAIT_DATA;

  logic [MEM_DATA_BITS-1:0] ram [0:(1<<DEPTH_LOG2)-1];

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_idx_q, wr_idx_d;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  data_fire;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same lines.
  assign req_idx = mem.mem_req_addr[DEPTH_LOG2-1:0];

  generate
    if (DEPTH_LOG2 < MEM_ADDR_BITS) begin : g_addr_hi
      assign unused_addr_hi = ^mem.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];
    end else begin : g_addr_full
      assign unused_addr_hi = 1'b0;
    end
  endgenerate

  assign mem.mem_req_ready      = reset && (state_q == S_IDLE);
  assign mem.mem_req_data_ready = (state_q == S_WAIT_DATA);

  assign req_fire  = mem.mem_req_valid && mem.mem_req_ready;
  assign rd_fire   = req_fire && !mem.mem_req_rw;
  assign data_fire = mem.mem_req_data_valid && mem.mem_req_data_ready;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire && mem.mem_req_rw) begin
          wr_idx_d = req_idx;
          state_d  = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (data_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  // Contents survive reset; a beat can only land while in WAIT_DATA.
  always_ff @(posedge clk) begin
    if (data_fire) begin
      for (int b = 0; b < MEM_MASK_BITS; b++) begin
        if (mem.mem_req_data_mask[b]) begin
          ram[wr_idx_q][8*b +: 8] <= mem.mem_req_data_bits[8*b +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(
    .LATENCY   (READ_LATENCY),
    .TAG_BITS  (MEM_TAG_BITS),
    .DATA_BITS (MEM_DATA_BITS)
  ) u_resp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_fire),
    .in_tag    (mem.mem_req_tag),
    .in_data   (ram[req_idx]),
    .out_valid (mem.mem_resp_valid),
    .out_tag   (mem.mem_resp_tag),
    .out_data  (mem.mem_resp_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ext_mem_model : scoreboard bench for ext_mem_model
// Revision         : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ext_mem_model;
  import mem_if_pkg::*;

  localparam int LAT        = 4;
  localparam int DEPTH_LOG2 = 14;

  typedef struct {
    logic [MEM_TAG_BITS-1:0]  tag;
    logic [MEM_DATA_BITS-1:0] data;
    int                       cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [MEM_DATA_BITS-1:0] model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ext_mem_model_if mem();

  ext_mem_model #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .READ_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem)
  );

  // Response monitor: every valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (mem.mem_resp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got tag=%0d data=%h at cyc %0d, required no response",
                 mem.mem_resp_tag, mem.mem_resp_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mem.mem_resp_tag !== mon_e.tag || mem.mem_resp_data !== mon_e.data || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL resp_match: got tag=%0d data=%h cyc=%0d, required tag=%0d data=%h cyc=%0d",
                   mem.mem_resp_tag, mem.mem_resp_data, cyc, mon_e.tag, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  function automatic int idx_of(input logic [MEM_ADDR_BITS-1:0] a);
    return int'(a[DEPTH_LOG2-1:0]);
  endfunction

  task automatic preload(input int idx, input logic [MEM_DATA_BITS-1:0] v);
    dut.ram[idx] = v;
    model[idx]   = v;
  endtask

  task automatic do_read(input logic [MEM_ADDR_BITS-1:0] a, input logic [MEM_TAG_BITS-1:0] t);
    exp_t e;
    mem.mem_req_valid = 1'b1;
    mem.mem_req_rw    = 1'b0;
    mem.mem_req_addr  = a;
    mem.mem_req_tag   = t;
    checks++;
    if (mem.mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_req_ready: got %b, required 1", mem.mem_req_ready);
    end
    e.tag  = t;
    e.data = model[idx_of(a)];
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic req_idle();
    mem.mem_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [MEM_ADDR_BITS-1:0] a,
                          input logic [MEM_DATA_BITS-1:0] d,
                          input logic [MEM_MASK_BITS-1:0] m);
    int idx;
    idx = idx_of(a);
    mem.mem_req_valid = 1'b1;
    mem.mem_req_rw    = 1'b1;
    mem.mem_req_addr  = a;
    checks++;
    if (mem.mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_req_ready: got %b, required 1", mem.mem_req_ready);
    end
    @(negedge clk);
    mem.mem_req_valid = 1'b0;
    checks++;
    if (mem.mem_req_ready !== 1'b0 || mem.mem_req_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_wait_data: got ready=%b data_ready=%b, required 0/1",
               mem.mem_req_ready, mem.mem_req_data_ready);
    end
    mem.mem_req_data_valid = 1'b1;
    mem.mem_req_data_bits  = d;
    mem.mem_req_data_mask  = m;
    @(negedge clk);
    mem.mem_req_data_valid = 1'b0;
    checks++;
    if (mem.mem_req_ready !== 1'b1 || mem.mem_req_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_back_idle: got ready=%b data_ready=%b, required 1/0",
               mem.mem_req_ready, mem.mem_req_data_ready);
    end
    for (int b = 0; b < MEM_MASK_BITS; b++) begin
      if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < LAT + 4 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d responses outstanding, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem.mem_req_ready !== 1'b0 || mem.mem_req_data_ready !== 1'b0 || mem.mem_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b data_ready=%b resp_valid=%b, required 0/0/0",
               mem.mem_req_ready, mem.mem_req_data_ready, mem.mem_resp_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem.mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", mem.mem_req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_read_latency();
    preload(12'h2ff, 128'h00000000_12345678_9ABCDEF0_0F1E2D3C);
    do_read(28'h2ff, 5'd3);
    req_idle();
    drain("read_latency");
  endtask

  task automatic test_write();
    preload(16'h10, {128{1'b1}});
    do_write(28'h10, {16{8'hAA}}, 16'h000F);
    checks++;
    if (dut.ram[16'h10] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_AAAAAAAA) begin
      errors++;
      $display("FAIL write_mask: got %h, required %h", dut.ram[16'h10],
               128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_AAAAAAAA);
    end
    do_read(28'h10, 5'd9);
    req_idle();
    drain("write_readback");
  endtask

  task automatic test_mask_zero();
    preload(16'h20, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    do_write(28'h20, '0, '0);
    checks++;
    if (dut.ram[16'h20] !== 128'h01234567_89ABCDEF_FEDCBA98_76543210) begin
      errors++;
      $display("FAIL mask_zero: got %h, required %h", dut.ram[16'h20],
               128'h01234567_89ABCDEF_FEDCBA98_76543210);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) preload(i, {4{32'hC0DE0000 + 32'(i)}});
    for (int i = 0; i < 4; i++) do_read(28'(i), 5'(i));
    req_idle();
    drain("back_to_back");
  endtask

  task automatic test_wrap();
    preload(5, 128'h55555555_00000005_AAAAAAAA_50505050);
    preload(6, 128'h0);
    do_read(28'h4005, 5'd7);
    req_idle();
    drain("wrap_read");
    do_write(28'h4006, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'hFFFF);
    checks++;
    if (dut.ram[6] !== 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0) begin
      errors++;
      $display("FAIL wrap_write: got %h, required %h", dut.ram[6],
               128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
    end
  endtask

  task automatic test_data_valid_idle();
    mem.mem_req_data_valid = 1'b1;
    mem.mem_req_data_bits  = '0;
    mem.mem_req_data_mask  = '1;
    #1;
    checks++;
    if (mem.mem_req_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_data_ready: got %b, required 0", mem.mem_req_data_ready);
    end
    @(negedge clk);
    mem.mem_req_data_valid = 1'b0;
    checks++;
    if (dut.ram[6] !== model[6] || mem.mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_data_ignored: got ram=%h ready=%b, required ram=%h ready=1",
               dut.ram[6], mem.mem_req_ready, model[6]);
    end
  endtask

  task automatic test_reset_mid();
    preload(16'h40, 128'h40404040_40404040_40404040_40404040);
    preload(16'h41, 128'h41414141_41414141_41414141_41414141);
    preload(16'h50, 128'h50505050_50505050_50505050_50505050);
    do_read(28'h40, 5'd1);
    do_read(28'h41, 5'd2);
    mem.mem_req_valid = 1'b1;
    mem.mem_req_rw    = 1'b1;
    mem.mem_req_addr  = 28'h50;
    @(negedge clk);
    mem.mem_req_valid      = 1'b0;
    mem.mem_req_data_valid = 1'b1;
    mem.mem_req_data_bits  = '0;
    mem.mem_req_data_mask  = '1;
    #2 reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (mem.mem_req_ready !== 1'b0 || mem.mem_req_data_ready !== 1'b0 || mem.mem_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b data_ready=%b resp_valid=%b, required 0/0/0",
               mem.mem_req_ready, mem.mem_req_data_ready, mem.mem_resp_valid);
    end
    repeat (2) @(negedge clk);
    mem.mem_req_data_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (mem.mem_req_ready !== 1'b1 || mem.mem_req_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got ready=%b data_ready=%b, required 1/0",
               mem.mem_req_ready, mem.mem_req_data_ready);
    end
    repeat (LAT + 3) @(negedge clk);
    checks++;
    if (dut.ram[16'h50] !== 128'h50505050_50505050_50505050_50505050) begin
      errors++;
      $display("FAIL reset_mid_ram: got %h, required %h", dut.ram[16'h50],
               128'h50505050_50505050_50505050_50505050);
    end
  endtask

  initial begin
    mem.mem_req_valid      = 1'b0;
    mem.mem_req_rw         = 1'b0;
    mem.mem_req_addr       = '0;
    mem.mem_req_tag        = '0;
    mem.mem_req_data_valid = 1'b0;
    mem.mem_req_data_bits  = '0;
    mem.mem_req_data_mask  = '0;

    test_reset();
    test_read_latency();
    test_write();
    test_mask_zero();
    test_back_to_back();
    test_wrap();
    test_data_valid_idle();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ext_mem_model.md
Name: ext_mem_model

Overview:
- Behavioural-but-synthesizable main-memory model on the cache-refill side of the RISC-V core (riscv_top).
- Accepts line-granular read/write requests over a valid/ready request channel, plus a separate write-data channel.
- Returns read data with the request tag after a fixed latency.
- Storage is an array named ram; benches preload it hierarchically with $readmemh and inspect it directly.

Parameters:
- MEM_DATA_BITS, 128, line/beat width; one ram entry = four 32-bit words, word k at bits [32k+:32].
- MEM_ADDR_BITS, 28, request address in 16-byte line units (byte address = {addr, 4'b0}).
- MEM_TAG_BITS, 5, request/response tag width.
- DEPTH_LOG2, 14, log2 of ram entries.
- READ_LATENCY, 4, cycles from read acceptance to mem_resp_valid (≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- mem_req_valid  in  1  request present.
- mem_req_ready  out  1  request accepted when valid&&ready.
- mem_req_rw  in  1  1=write, 0=read.
- mem_req_addr  in  MEM_ADDR_BITS  line address.
- mem_req_tag  in  MEM_TAG_BITS  read tag, echoed on response.
- mem_req_data_valid  in  1  write-data beat present.
- mem_req_data_ready  out  1  beat accepted when valid&&ready.
- mem_req_data_bits  in  MEM_DATA_BITS  write data.
- mem_req_data_mask  in  MEM_DATA_BITS/8  byte enables, bit i → bits [8i+:8].
- mem_resp_valid  out  1  read data valid, single cycle; no backpressure.
- mem_resp_tag  out  MEM_TAG_BITS  tag of the completing read.
- mem_resp_data  out  MEM_DATA_BITS  read line.

Behaviour:
- Array: ram[0:2^DEPTH_LOG2-1] of MEM_DATA_BITS.
  - Indexed by mem_req_addr[DEPTH_LOG2-1:0]; higher address bits are ignored (aliasing wrap).
  - ram is never cleared by reset.
- FSM states: IDLE, WAIT_DATA.
  - IDLE: mem_req_ready=1, mem_req_data_ready=0.
  - Read accepted in IDLE: capture ram[index] and tag into the latency pipeline; stay in IDLE. Back-to-back reads are allowed, one per cycle.
  - Write accepted in IDLE: latch the index; go to WAIT_DATA.
  - WAIT_DATA: mem_req_ready=0, mem_req_data_ready=1.
  - Beat accepted in WAIT_DATA: every masked byte of ram[latched index] is updated at that edge; return to IDLE.
  - mem_req_data_valid in IDLE is ignored, not accepted.
- Writes produce no response.
- Read latency: a read accepted at edge N gives mem_resp_valid=1 during the cycle after edge N+READ_LATENCY-1.
  - READ_LATENCY=1 means valid in the cycle right after acceptance.
  - Data is the ram contents at acceptance; a write completed at or before the acceptance edge is visible.
  - Responses stay in request order.
- Pipeline: READ_LATENCY-deep shift register of {valid, tag, data}.
  - Outputs come from the last stage.
  - mem_resp_data and mem_resp_tag may hold stale values when valid=0.
- Mask 0 completes the write handshake with no ram change.
- Reset asserted (low), at any time, including mid-write or with reads in flight:
  - state=IDLE, all pipeline valids cleared.
  - mem_resp_valid=0, mem_req_data_ready=0.
  - mem_req_ready is forced to 0 while reset is low.
  - The pending write is dropped.
- Reset release: mem_req_ready=1 in the first cycle after release.

Decomposition:
- Shared package mem_if_pkg: MEM_DATA_BITS, MEM_ADDR_BITS, MEM_TAG_BITS, and the FSM state enum (IDLE, WAIT_DATA). Matches the codebase constants in const.vh.
- One sub-module, mem_resp_pipe: the parameterised READ_LATENCY shift register of {valid, tag, data}, with async active-low clear.

Test Plan:
- Preload ram[0x2ff] = 0x...0000_0000_1234_5678_..., read addr 0x2ff tag 3 → after READ_LATENCY cycles mem_resp_valid=1 for one cycle, tag=3, data=ram[0x2ff].
- Write addr 0x10, data all 0xAA, mask 0x000F, over the pre-written line 0xFF…FF.
  - ready drops the cycle after request acceptance.
  - After the beat, ram[0x10] = 0xFF…FF_AAAAAAAA; a subsequent read returns the same.
- Four back-to-back reads, tags 0–3, addrs 0–3 → four consecutive response cycles, tags 0,1,2,3 in order.
- Address 0x4000+5 with DEPTH_LOG2=14 → accesses ram[5] (wrap).
- Assert reset low during WAIT_DATA with two reads in flight → no responses, ram unchanged, mem_req_ready=1 the cycle after release.
- mem_req_data_valid pulsed while IDLE → mem_req_data_ready=0, ram unchanged.
